memoria_dados_resp: RTL and testbench
=====================================

# memoria_dados_resp

Multicycle data-memory responder on the datapath side of the control FSM. Accepts one doubleword read (`ld`) or write (`sd`) request at a time, inserts a programmable number of wait states, performs the access on an internal DEPTH×64-bit array, and returns read data with a one-cycle PRONTO pulse. The control FSM holds in its memory-wait states until PRONTO is seen.

## Interface
- DEPTH, 256: number of 64-bit doublewords (power of two, 2..4096).
- LATENCIA, 2: wait-state cycles per access (0..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous and active-low.
- RD_MEM  in  1  read request; sampled only in OCIOSO.
- WR_MEM  in  1  write request; sampled only in OCIOSO.
- ENDERECO  in  64  byte address (ALU output).
- DADO_ESCRITA  in  64  write data (register B).
- DADO_LEITURA  out  64  registered read data; holds its value until the next successful read.
- PRONTO  out  1  one-cycle completion pulse.
- ERRO  out  1  one-cycle pulse coincident with PRONTO when the access was rejected.
- OCUPADO  out  1  high in every state except OCIOSO.

## Operation
- States: OCIOSO, ESPERA, ACESSO, RESPOSTA.
- In OCIOSO, RD_MEM or WR_MEM high captures ENDERECO, DADO_ESCRITA and the request type into internal registers.
  - If LATENCIA > 0: next state is ESPERA, with the wait counter loaded with LATENCIA−1.
  - If LATENCIA = 0: next state is ACESSO.
- ESPERA: counter decrements each cycle; when it is 0, next state is ACESSO.
- ACESSO lasts one cycle. On its closing edge:
  - a write stores the captured data at index = ENDERECO[3 +: log2(DEPTH)];
  - a read loads DADO_LEITURA from the array.
  - Next state is RESPOSTA.
- RESPOSTA: PRONTO=1 for exactly one cycle, then OCIOSO.
- Rejection conditions, evaluated at capture: ENDERECO ≥ DEPTH×8 (out of range), or RD_MEM and WR_MEM both high.
  - A rejected access still walks the full state sequence with the same latency.
  - It does not modify the array or DADO_LEITURA.
  - ERRO=1 in RESPOSTA.
- RD_MEM, WR_MEM, ENDERECO and DADO_ESCRITA are ignored outside OCIOSO. They may change freely once captured.
- Array contents are not reset. Uninitialised reads return X in simulation.

## Timing
- Reset values: DADO_LEITURA=0, PRONTO=0, ERRO=0, OCUPADO=0, state=OCIOSO, wait counter=0.
- Request high in cycle T (OCIOSO):
  - OCUPADO high from T+1 through T+LATENCIA+2;
  - PRONTO high in cycle T+LATENCIA+2;
  - read data valid in DADO_LEITURA from cycle T+LATENCIA+2 onward.
- Earliest next accept is T+LATENCIA+3, giving throughput of one access per LATENCIA+3 cycles.
- Back-to-back: a request held high across RESPOSTA is accepted in the following OCIOSO cycle and is not lost.
- Reset asserted mid-operation:
  - immediate return to OCIOSO, all outputs reset;
  - a write still in OCIOSO or ESPERA is discarded;
  - a write whose ACESSO closing edge already occurred stays committed.

## Configuration
- MEM_ALINHAMENTO_CHECK_EN
  - Defined: ENDERECO[2:0] ≠ 0 is an additional rejection condition. The access is blocked and ERRO pulses with PRONTO.
  - Undefined: ENDERECO[2:0] is ignored. Accesses are silently aligned down to the doubleword. The out-of-range and double-request checks remain.

## Test plan
- Reset, then write 0x0123456789ABCDEF at address 0x10 with LATENCIA=2 -> PRONTO exactly 4 cycles after the request cycle, ERRO=0. A read of 0x10 returns 0x0123456789ABCDEF, and DADO_LEITURA holds it afterward.
- LATENCIA=0, read of address 0x10 -> PRONTO 2 cycles after the request, with OCUPADO high for exactly 2 cycles.
- Read of address DEPTH×8 (0x800 at default DEPTH) -> ERRO=1 with PRONTO at the normal latency, DADO_LEITURA unchanged, array unchanged.
- RD_MEM=WR_MEM=1 at address 0x18 -> ERRO pulse. A follow-up read of 0x18 returns its prior value.
- Write 0xAAAA…AA to address 0x20, with RST pulled low during ESPERA -> all outputs return to 0 asynchronously. A later read of 0x20 returns the old contents.
- Address 0x13 with MEM_ALINHAMENTO_CHECK_EN defined -> ERRO=1, no write. Without the macro -> the write lands at doubleword 0x10 and ERRO=0.

Source files
------------

// File: rtl/memoria_dados_resp.sv
// Multicycle data-memory responder: one 64-bit ld/sd at a time on a DEPTH x 64 array.
// Latency: PRONTO pulses LATENCIA+2 cycles after the request is accepted in OCIOSO.
// Backpressure: requests are only sampled in OCIOSO; OCUPADO is high whenever a request would be ignored.
// Optional: define MEM_ALINHAMENTO_CHECK_EN to reject addresses that are not doubleword-aligned.
module memoria_dados_resp #(
  parameter int DEPTH    = 256,
  parameter int LATENCIA = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RD_MEM,
  input  logic        WR_MEM,
  input  logic [63:0] ENDERECO,
  input  logic [63:0] DADO_ESCRITA,
  output logic [63:0] DADO_LEITURA,
  output logic        PRONTO,
  output logic        ERRO,
  output logic        OCUPADO
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = LATENCIA[3:0];

  typedef enum logic [1:0] {OCIOSO, ESPERA, ACESSO, RESPOSTA} estado_t;

  estado_t       estado_q, estado_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [63:0]   dado_q, dado_d;
  logic          escrita_q, escrita_d;
  logic          rejeita_q, rejeita_d;
  logic [63:0]   leitura_q, leitura_d;

  logic [63:0]   mem [DEPTH];
  logic          mem_we;

  logic          fora_faixa;
  logic          pedido_duplo;
  logic          desalinhado;
  logic          rejeita_novo;

  // Anything at or above DEPTH*8 has a bit set above the doubleword index field.
  assign fora_faixa   = |ENDERECO[63:AW+3];
  assign pedido_duplo = RD_MEM & WR_MEM;

`ifdef MEM_ALINHAMENTO_CHECK_EN
  assign desalinhado = |ENDERECO[2:0];
`else
  // Byte offset is dropped: the access is aligned down to its doubleword.
  logic unused_byte_off;
  assign unused_byte_off = ^ENDERECO[2:0];
  assign desalinhado     = 1'b0;
`endif

  assign rejeita_novo = fora_faixa | pedido_duplo | desalinhado;

  // Next-state, capture, and access decisions for the request sequencer.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dado_d    = dado_q;
    escrita_d = escrita_q;
    rejeita_d = rejeita_q;
    leitura_d = leitura_q;
    mem_we    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (RD_MEM || WR_MEM) begin
          idx_d     = ENDERECO[3 +: AW];
          dado_d    = DADO_ESCRITA;
          escrita_d = WR_MEM;
          rejeita_d = rejeita_novo;
          if (LAT == 4'd0) begin
            estado_d = ACESSO;
          end else begin
            estado_d = ESPERA;
            cnt_d    = LAT - 4'd1;
          end
        end
      end
      ESPERA: begin
        if (cnt_q == 4'd0) begin
          estado_d = ACESSO;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACESSO: begin
        estado_d = RESPOSTA;
        // A rejected access walks the same states but touches nothing.
        if (!rejeita_q) begin
          if (escrita_q) begin
            mem_we = 1'b1;
          end else begin
            leitura_d = mem[idx_q];
          end
        end
      end
      RESPOSTA: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Control and captured-request registers; reset abandons any in-flight access.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      estado_q  <= OCIOSO;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      dado_q    <= 64'd0;
      escrita_q <= 1'b0;
      rejeita_q <= 1'b0;
      leitura_q <= 64'd0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dado_q    <= dado_d;
      escrita_q <= escrita_d;
      rejeita_q <= rejeita_d;
      leitura_q <= leitura_d;
    end
  end

  // Storage array is not reset; a write commits on the ACESSO closing edge.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx_q] <= dado_q;
    end
  end

  assign DADO_LEITURA = leitura_q;
  assign PRONTO       = (estado_q == RESPOSTA);
  assign ERRO         = (estado_q == RESPOSTA) && rejeita_q;
  assign OCUPADO      = (estado_q != OCIOSO);

endmodule

// File: tb/tb_memoria_dados_resp.sv
// Bench for memoria_dados_resp: one instance with LATENCIA=2, one with LATENCIA=0,
// both driven by the same request bus so their arrays hold identical contents.
module tb_memoria_dados_resp;

`ifdef MEM_ALINHAMENTO_CHECK_EN
  localparam logic ALIGN_CHK = 1'b1;
`else
  localparam logic ALIGN_CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        rd_mem;
  logic        wr_mem;
  logic [63:0] endereco;
  logic [63:0] dado_escrita;

  logic [63:0] leitura2, leitura0;
  logic        pronto2, pronto0;
  logic        erro2, erro0;
  logic        ocup2, ocup0;

  int checks   = 0;
  int failures = 0;

  memoria_dados_resp #(.DEPTH(256), .LATENCIA(2)) u_dut2 (
    .CLK(clk), .RST(rst), .RD_MEM(rd_mem), .WR_MEM(wr_mem),
    .ENDERECO(endereco), .DADO_ESCRITA(dado_escrita),
    .DADO_LEITURA(leitura2), .PRONTO(pronto2), .ERRO(erro2), .OCUPADO(ocup2)
  );

  memoria_dados_resp #(.DEPTH(256), .LATENCIA(0)) u_dut0 (
    .CLK(clk), .RST(rst), .RD_MEM(rd_mem), .WR_MEM(wr_mem),
    .ENDERECO(endereco), .DADO_ESCRITA(dado_escrita),
    .DADO_LEITURA(leitura0), .PRONTO(pronto0), .ERRO(erro0), .OCUPADO(ocup0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_erro;
    logic        chk_rd;
    logic [63:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One request held for a single cycle; reports completion latency, busy cycles, ERRO and read data.
  task automatic access(input bit sel0, input logic r, input logic w,
                        input logic [63:0] a, input logic [63:0] d,
                        output int lat, output int ocu,
                        output logic erro_s, output logic [63:0] rd_s);
    int k;
    @(negedge clk);
    rd_mem = r; wr_mem = w; endereco = a; dado_escrita = d;
    @(negedge clk);
    // Garbage on the bus after capture must not matter.
    rd_mem = 1'b0; wr_mem = 1'b0; endereco = '1; dado_escrita = '1;
    k = 1; ocu = 0; lat = -1; erro_s = 1'bx; rd_s = 'x;
    while (lat < 0 && k < 40) begin
      if (sel0 ? ocup0 : ocup2) ocu++;
      if (sel0 ? pronto0 : pronto2) begin
        lat    = k;
        erro_s = sel0 ? erro0 : erro2;
        rd_s   = sel0 ? leitura0 : leitura2;
      end else begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  vec_t        vecs[14];
  int          lat, ocu;
  logic        e_s;
  logic [63:0] r_s;
  logic [8:0]  pat;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 64'h10,  64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 64'h10,  64'h0,                1'b0, 1'b1, 64'h0123456789ABCDEF};
    vecs[2]  = '{1'b1, 1'b0, 64'h800, 64'h0,                1'b1, 1'b1, 64'h0123456789ABCDEF};
    vecs[3]  = '{1'b0, 1'b1, 64'h810, 64'hBADBADBADBADBAD0, 1'b1, 1'b0, 64'h0};
    vecs[4]  = '{1'b1, 1'b0, 64'h10,  64'h0,                1'b0, 1'b1, 64'h0123456789ABCDEF};
    vecs[5]  = '{1'b0, 1'b1, 64'h18,  64'h1111111111111111, 1'b0, 1'b0, 64'h0};
    vecs[6]  = '{1'b1, 1'b1, 64'h18,  64'hDEADBEEFDEADBEEF, 1'b1, 1'b1, 64'h0123456789ABCDEF};
    vecs[7]  = '{1'b1, 1'b0, 64'h18,  64'h0,                1'b0, 1'b1, 64'h1111111111111111};
    vecs[8]  = '{1'b0, 1'b1, 64'h20,  64'h5555555555555555, 1'b0, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 1'b1, 64'h7F8, 64'h0F0F0F0F0F0F0F0F, 1'b0, 1'b0, 64'h0};
    vecs[10] = '{1'b1, 1'b0, 64'h7F8, 64'h0,                1'b0, 1'b1, 64'h0F0F0F0F0F0F0F0F};
    vecs[11] = '{1'b0, 1'b1, 64'h13,  64'h7777777777777777, ALIGN_CHK, 1'b0, 64'h0};
    vecs[12] = '{1'b1, 1'b0, 64'h10,  64'h0,                1'b0, 1'b1,
                 ALIGN_CHK ? 64'h0123456789ABCDEF : 64'h7777777777777777};
    vecs[13] = '{1'b1, 1'b0, 64'h20,  64'h0,                1'b0, 1'b1, 64'h5555555555555555};

    rst = 1'b0; rd_mem = 1'b0; wr_mem = 1'b0; endereco = '0; dado_escrita = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_dado_leitura", leitura2, 64'h0);
    chk("reset_pronto", {63'd0, pronto2}, 64'd0);
    chk("reset_erro", {63'd0, erro2}, 64'd0);
    chk("reset_ocupado", {63'd0, ocup2}, 64'd0);
    rst = 1'b1;

    // Table: LATENCIA=2 instance, PRONTO 4 cycles after the request and busy for 4 cycles.
    for (int i = 0; i < 14; i++) begin
      access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, ocu, e_s, r_s);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("v%0d_ocupado_cycles", i), 64'(ocu), 64'd4);
      chk($sformatf("v%0d_erro", i), {63'd0, e_s}, {63'd0, vecs[i].exp_erro});
      if (vecs[i].chk_rd) chk($sformatf("v%0d_dado_leitura", i), r_s, vecs[i].exp_rd);
      @(negedge clk);
      chk($sformatf("v%0d_pronto_one_cycle", i), {63'd0, pronto2}, 64'd0);
      chk($sformatf("v%0d_dado_hold", i), leitura2, r_s);
    end

    // Request held across RESPOSTA: accepted again right after, PRONTO at T+4 and T+9.
    @(negedge clk);
    rd_mem = 1'b1; endereco = 64'h18;
    pat = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      pat[k-1] = pronto2;
    end
    rd_mem = 1'b0;
    chk("b2b_pronto_pattern", {55'd0, pat}, {55'd0, 9'b100001000});
    repeat (4) @(negedge clk);
    chk("b2b_dado_leitura", leitura2, 64'h1111111111111111);

    // Reset pulled during ESPERA of a write: outputs clear at once, write discarded.
    @(negedge clk);
    wr_mem = 1'b1; endereco = 64'h20; dado_escrita = 64'hAAAAAAAAAAAAAAAA;
    @(negedge clk);
    wr_mem = 1'b0;
    chk("midrst_busy_before", {63'd0, ocup2}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_dado_leitura", leitura2, 64'h0);
    chk("midrst_ocupado", {63'd0, ocup2}, 64'd0);
    chk("midrst_pronto", {63'd0, pronto2}, 64'd0);
    chk("midrst_erro", {63'd0, erro2}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    access(1'b0, 1'b1, 1'b0, 64'h20, 64'h0, lat, ocu, e_s, r_s);
    chk("midrst_readback", r_s, 64'h5555555555555555);
    chk("midrst_readback_latency", 64'(lat), 64'd4);

    // LATENCIA=0 instance: PRONTO 2 cycles after the request, busy exactly 2 cycles.
    access(1'b1, 1'b1, 1'b0, 64'h10, 64'h0, lat, ocu, e_s, r_s);
    chk("lat0_latency", 64'(lat), 64'd2);
    chk("lat0_ocupado_cycles", 64'(ocu), 64'd2);
    chk("lat0_erro", {63'd0, e_s}, 64'd0);
    chk("lat0_dado_leitura", r_s,
        ALIGN_CHK ? 64'h0123456789ABCDEF : 64'h7777777777777777);
    @(negedge clk);
    chk("lat0_pronto_one_cycle", {63'd0, pronto0}, 64'd0);
    repeat (4) @(negedge clk);
    access(1'b1, 1'b0, 1'b1, 64'h800, 64'h0, lat, ocu, e_s, r_s);
    chk("lat0_oob_latency", 64'(lat), 64'd2);
    chk("lat0_oob_erro", {63'd0, e_s}, 64'd1);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
